// File: rtl/dec8b10b_pkg.sv
// Shared types and code constants for the multi-lane 8b/10b decoder.
package dec8b10b_pkg;

   localparam int unsigned SYM_W  = 10;
   localparam int unsigned DATA_W = 8;

   // Word-synchronisation states
   typedef enum logic [2:0] {
      LOS  = 3'd0,
      CD1  = 3'd1,
      CD2  = 3'd2,
      CD3  = 3'd3,
      SYNC = 3'd4
   } sync_state_e;

   // 6b sub-blocks with special disparity handling
   localparam logic [5:0] C6_K28_N = 6'b001111;
   localparam logic [5:0] C6_K28_P = 6'b110000;
   localparam logic [5:0] C6_D07_N = 6'b111000;
   localparam logic [5:0] C6_D07_P = 6'b000111;

   // 4b sub-blocks with special disparity handling
   localparam logic [3:0] C4_D3_N = 4'b1100;
   localparam logic [3:0] C4_D3_P = 4'b0011;
   localparam logic [3:0] C4_A7_N = 4'b0111;
   localparam logic [3:0] C4_A7_P = 4'b1000;

   // Comma patterns on symbol bits [9:3]
   localparam logic [6:0] COMMA_N = 7'b0011111;
   localparam logic [6:0] COMMA_P = 7'b1100000;

   // Common K-code symbols
   localparam logic [9:0] K28_5_N = 10'b0011111010;
   localparam logic [9:0] K28_5_P = 10'b1100000101;

endpackage

// File: rtl/dec8b10b_if.sv
// Decoder bus: input symbols and registered decode results.
// Optional DEC8B10B_ERR_CNT_EN adds err_clr / err_count.
interface dec8b10b_if #(
   parameter int unsigned LANES = 1
);
   logic                 in_valid;
   logic [10*LANES-1:0]  in_sym;
   logic                 out_valid;
   logic [8*LANES-1:0]   out_data;
   logic [LANES-1:0]     out_k;
   logic [LANES-1:0]     code_err;
   logic [LANES-1:0]     disp_err;
   logic [LANES-1:0]     comma;
   logic                 rd;
   logic                 sync;
`ifdef DEC8B10B_ERR_CNT_EN
   logic                 err_clr;
   logic [15:0]          err_count;

   modport master (output in_valid, in_sym, err_clr,
                   input  out_valid, out_data, out_k, code_err, disp_err, comma, rd, sync, err_count);
   modport slave  (input  in_valid, in_sym, err_clr,
                   output out_valid, out_data, out_k, code_err, disp_err, comma, rd, sync, err_count);
`else
   modport master (output in_valid, in_sym,
                   input  out_valid, out_data, out_k, code_err, disp_err, comma, rd, sync);
   modport slave  (input  in_valid, in_sym,
                   output out_valid, out_data, out_k, code_err, disp_err, comma, rd, sync);
`endif
endinterface

// File: rtl/dec8b10b_lane.sv
// Combinational decode of one 10b symbol against an incoming running disparity.
module dec8b10b_lane
   import dec8b10b_pkg::*;
(
   input  logic [9:0] symbol,
   input  logic       rd_in,
   output logic [7:0] data,
   output logic       k,
   output logic       code_err,
   output logic       disp_err,
   output logic       comma,
   output logic       rd_out
);

   logic [5:0] sb6;
   logic [3:0] sb4;
   logic [3:0] f4;
   logic [4:0] v5;
   logic [2:0] v3;
   logic       ok6, ok4, is_k28, is_a7;
   logic [2:0] n6, n4;
   logic       rd_mid, bad6, bad4;

   // Table lookup, disparity check and RD update for both sub-blocks
   always_comb begin
      sb6    = symbol[9:4];
      sb4    = symbol[3:0];
      v5     = '0;
      v3     = '0;
      ok6    = 1'b1;
      ok4    = 1'b1;
      is_k28 = 1'b0;
      is_a7  = 1'b0;

      case (sb6)
         6'b100111, 6'b011000: v5 = 5'd0;
         6'b011101, 6'b100010: v5 = 5'd1;
         6'b101101, 6'b010010: v5 = 5'd2;
         6'b110001:            v5 = 5'd3;
         6'b110101, 6'b001010: v5 = 5'd4;
         6'b101001:            v5 = 5'd5;
         6'b011001:            v5 = 5'd6;
         C6_D07_N, C6_D07_P:   v5 = 5'd7;
         6'b111001, 6'b000110: v5 = 5'd8;
         6'b100101:            v5 = 5'd9;
         6'b010101:            v5 = 5'd10;
         6'b110100:            v5 = 5'd11;
         6'b001101:            v5 = 5'd12;
         6'b101100:            v5 = 5'd13;
         6'b011100:            v5 = 5'd14;
         6'b010111, 6'b101000: v5 = 5'd15;
         6'b011011, 6'b100100: v5 = 5'd16;
         6'b100011:            v5 = 5'd17;
         6'b010011:            v5 = 5'd18;
         6'b110010:            v5 = 5'd19;
         6'b001011:            v5 = 5'd20;
         6'b101010:            v5 = 5'd21;
         6'b011010:            v5 = 5'd22;
         6'b111010, 6'b000101: v5 = 5'd23;
         6'b110011, 6'b001100: v5 = 5'd24;
         6'b100110:            v5 = 5'd25;
         6'b010110:            v5 = 5'd26;
         6'b110110, 6'b001001: v5 = 5'd27;
         6'b001110:            v5 = 5'd28;
         6'b101110, 6'b010001: v5 = 5'd29;
         6'b011110, 6'b100001: v5 = 5'd30;
         6'b101011, 6'b010100: v5 = 5'd31;
         C6_K28_N, C6_K28_P: begin
            v5     = 5'd28;
            is_k28 = 1'b1;
         end
         default: ok6 = 1'b0;
      endcase

      // K28 fghj follows the 6b polarity; fold RD+ codes onto the RD- set
      f4 = (sb6 == C6_K28_P) ? ~sb4 : sb4;

      if (is_k28) begin
         case (f4)
            4'b0100: v3 = 3'd0;
            4'b1001: v3 = 3'd1;
            4'b0101: v3 = 3'd2;
            4'b0011: v3 = 3'd3;
            4'b0010: v3 = 3'd4;
            4'b1010: v3 = 3'd5;
            4'b0110: v3 = 3'd6;
            4'b1000: v3 = 3'd7;
            default: ok4 = 1'b0;
         endcase
      end else begin
         case (sb4)
            4'b1011, 4'b0100:  v3 = 3'd0;
            4'b1001:           v3 = 3'd1;
            4'b0101:           v3 = 3'd2;
            C4_D3_N, C4_D3_P:  v3 = 3'd3;
            4'b1101, 4'b0010:  v3 = 3'd4;
            4'b1010:           v3 = 3'd5;
            4'b0110:           v3 = 3'd6;
            4'b1110, 4'b0001:  v3 = 3'd7;
            C4_A7_N, C4_A7_P: begin
               v3    = 3'd7;
               is_a7 = 1'b1;
            end
            default: ok4 = 1'b0;
         endcase
      end

      n6 = 3'($countones(sb6));
      n4 = 3'($countones(sb4));

      bad6   = 1'b0;
      rd_mid = rd_in;
      if (n6 > 3'd3) begin
         bad6   = rd_in;
         rd_mid = 1'b1;
      end else if (n6 < 3'd3) begin
         bad6   = ~rd_in;
         rd_mid = 1'b0;
      end else if (sb6 == C6_D07_N) begin
         bad6 = rd_in;
      end else if (sb6 == C6_D07_P) begin
         bad6 = ~rd_in;
      end

      bad4   = 1'b0;
      rd_out = rd_mid;
      if (n4 > 3'd2) begin
         bad4   = rd_mid;
         rd_out = 1'b1;
      end else if (n4 < 3'd2) begin
         bad4   = ~rd_mid;
         rd_out = 1'b0;
      end else if (sb4 == C4_D3_N) begin
         bad4 = rd_mid;
      end else if (sb4 == C4_D3_P) begin
         bad4 = ~rd_mid;
      end

      code_err = ~(ok6 & ok4);
      disp_err = (bad6 | bad4) & ~code_err;
      data     = code_err ? 8'h00 : {v3, v5};
      k        = ~code_err & (is_k28 |
                  (is_a7 & ((v5 == 5'd23) | (v5 == 5'd27) | (v5 == 5'd29) | (v5 == 5'd30))));
      comma    = (symbol[9:3] == COMMA_N) | (symbol[9:3] == COMMA_P);
   end

endmodule

// File: rtl/dec8b10b_multi.sv
// Multi-lane 8b/10b decoder with RD chaining, registered outputs and word sync FSM.
// Optional DEC8B10B_ERR_CNT_EN adds a saturating per-lane error counter.
module dec8b10b_multi
   import dec8b10b_pkg::*;
#(
   parameter int unsigned LANES     = 1,
   parameter int unsigned ERR_LIMIT = 4,
   parameter int unsigned GOOD_RUN  = 4
) (
   input logic        clk,
   input logic        reset,
   dec8b10b_if.slave  bus
);

   localparam int unsigned EW = 3;
   localparam int unsigned GW = 4;

   logic [LANES:0]       rd_chain;
   logic [8*LANES-1:0]   dec_data;
   logic [LANES-1:0]     dec_k, dec_ce, dec_de, dec_cm;
   logic                 word_bad, comma_word;

   sync_state_e          state, state_nxt;
   logic [EW-1:0]        err_cnt, err_nxt;
   logic [GW-1:0]        good_cnt, good_nxt;

   assign rd_chain[0] = bus.rd;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      dec8b10b_lane u_lane (
         .symbol   (bus.in_sym[10*i +: 10]),
         .rd_in    (rd_chain[i]),
         .data     (dec_data[8*i +: 8]),
         .k        (dec_k[i]),
         .code_err (dec_ce[i]),
         .disp_err (dec_de[i]),
         .comma    (dec_cm[i]),
         .rd_out   (rd_chain[i+1])
      );
   end

   assign word_bad   = |(dec_ce | dec_de);
   assign comma_word = dec_cm[0] & ~word_bad;

   // Sync state and error-tolerance counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= LOS;
         err_cnt  <= '0;
         good_cnt <= '0;
      end else begin
         state    <= state_nxt;
         err_cnt  <= err_nxt;
         good_cnt <= good_nxt;
      end
   end

   // Next-state logic, advancing once per valid word
   always_comb begin
      state_nxt = state;
      err_nxt   = err_cnt;
      good_nxt  = good_cnt;
      if (bus.in_valid) begin
         case (state)
            LOS: if (comma_word) state_nxt = CD1;
            CD1: if (word_bad) state_nxt = LOS; else if (comma_word) state_nxt = CD2;
            CD2: if (word_bad) state_nxt = LOS; else if (comma_word) state_nxt = CD3;
            CD3: if (word_bad) state_nxt = LOS; else if (comma_word) state_nxt = SYNC;
            SYNC: begin
               if (word_bad) begin
                  if (32'(err_cnt) + 32'd1 >= ERR_LIMIT) begin
                     state_nxt = LOS;
                     err_nxt   = '0;
                     good_nxt  = '0;
                  end else begin
                     err_nxt  = err_cnt + EW'(1);
                     good_nxt = '0;
                  end
               end else if (32'(good_cnt) + 32'd1 >= GOOD_RUN) begin
                  if (err_cnt != '0) begin
                     err_nxt  = err_cnt - EW'(1);
                     good_nxt = '0;
                  end else begin
                     good_nxt = GW'(GOOD_RUN);
                  end
               end else begin
                  good_nxt = good_cnt + GW'(1);
               end
            end
            default: begin
               state_nxt = LOS;
               err_nxt   = '0;
               good_nxt  = '0;
            end
         endcase
      end
   end

   // Output register; data/status hold while no word is accepted
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_k     <= '0;
         bus.code_err  <= '0;
         bus.disp_err  <= '0;
         bus.comma     <= '0;
         bus.rd        <= 1'b0;
         bus.sync      <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.out_data <= dec_data;
            bus.out_k    <= dec_k;
            bus.code_err <= dec_ce;
            bus.disp_err <= dec_de;
            bus.comma    <= dec_cm;
            bus.rd       <= rd_chain[LANES];
            bus.sync     <= (state_nxt == SYNC);
         end
      end
   end

`ifdef DEC8B10B_ERR_CNT_EN
   logic [16:0] err_sum;

   // Running total of bad lanes in this word
   always_comb err_sum = {1'b0, bus.err_count} + 17'($countones(dec_ce | dec_de));

   // Saturating error counter; clear wins over a same-cycle increment
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.err_count <= '0;
      end else if (bus.err_clr) begin
         bus.err_count <= '0;
      end else if (bus.in_valid) begin
         bus.err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      end
   end
`endif

endmodule
